sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/cpu_pkg.sv | 15 +
 rtl/sram_arbiter_if.sv | 44 ++++
 rtl/sram_arbiter.sv | 121 ++++++++++++
 tb/tb_sram_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and SRAM arbiter state encoding
package cpu_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 8;
  localparam int STARVE_LIM_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_CAP  = 2'd2,
    ST_ACK  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - decoder, LCD and SRAM signal bundle around the arbiter
interface sram_arbiter_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              dec_rd_en;
  logic              dec_wr_en;
  logic [ADDR_W-1:0] dec_addr;
  logic [DATA_W-1:0] dec_wr_data;
  logic [DATA_W-1:0] dec_rd_data;
  logic              dec_ack;
  logic              dec_wait;

  logic              loc_req;
  logic [ADDR_W-1:0] data_loc;
  logic [DATA_W-1:0] lcd_data;
  logic              lcd_ack;

  logic [ADDR_W-1:0] sram_addr;
  logic              sram_rd_en;
  logic              sram_wr_en;
  logic [DATA_W-1:0] sram_wr_data;
  logic [DATA_W-1:0] sram_rd_data;

  // The arbiter itself.
  modport slave (
    input  dec_rd_en, dec_wr_en, dec_addr, dec_wr_data,
    input  loc_req, data_loc, sram_rd_data,
    output dec_rd_data, dec_ack, dec_wait, lcd_data, lcd_ack,
    output sram_addr, sram_rd_en, sram_wr_en, sram_wr_data
  );

  // The requesters plus the SRAM, seen from outside the arbiter.
  modport master (
    output dec_rd_en, dec_wr_en, dec_addr, dec_wr_data,
    output loc_req, data_loc, sram_rd_data,
    input  dec_rd_data, dec_ack, dec_wait, lcd_data, lcd_ack,
    input  sram_addr, sram_rd_en, sram_wr_en, sram_wr_data
  );

endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port (decoder r/w, LCD read) single-SRAM arbiter
// with decoder priority and a bounded LCD starvation counter.
module sram_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic           clk,
  input  logic           sys_rst,
  sram_arbiter_if.slave  bus
);

  localparam int            CW  = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  arb_state_t        state, state_nxt;
  logic [CW-1:0]     starve_cnt, starve_nxt;
  logic              grant, grant_lcd, grant_wr;
  logic              rd_en_nxt, wr_en_nxt, dec_ack_nxt, lcd_ack_nxt;
  logic              sel_lcd, op_wr;
  logic              rd_en_q, wr_en_q, dec_ack_q, lcd_ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, dec_rd_q, lcd_rd_q;
  logic              dec_req;

  assign dec_req = bus.dec_rd_en | bus.dec_wr_en;

  always_comb begin
    state_nxt   = state;
    starve_nxt  = starve_cnt;
    grant       = 1'b0;
    grant_lcd   = 1'b0;
    grant_wr    = 1'b0;
    rd_en_nxt   = 1'b0;
    wr_en_nxt   = 1'b0;
    dec_ack_nxt = 1'b0;
    lcd_ack_nxt = 1'b0;
    if (!bus.loc_req) starve_nxt = '0;
    case (state)
      ST_IDLE: begin
        if (dec_req || bus.loc_req) begin
          grant     = 1'b1;
          grant_lcd = bus.loc_req && (!dec_req || starve_cnt == LIM);
          // Write wins when the decoder raises both enables.
          grant_wr  = !grant_lcd && bus.dec_wr_en;
          rd_en_nxt = !grant_wr;
          wr_en_nxt = grant_wr;
          state_nxt = ST_ACC;
          if (grant_lcd)
            starve_nxt = '0;
          else if (bus.loc_req && starve_cnt != LIM)
            starve_nxt = starve_cnt + 1'b1;
        end
      end
      ST_ACC: begin
        if (op_wr) begin
          state_nxt   = ST_ACK;
          dec_ack_nxt = !sel_lcd;
          lcd_ack_nxt = sel_lcd;
        end else begin
          state_nxt = ST_CAP;
        end
      end
      ST_CAP: begin
        state_nxt   = ST_ACK;
        dec_ack_nxt = !sel_lcd;
        lcd_ack_nxt = sel_lcd;
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      sel_lcd    <= 1'b0;
      op_wr      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      dec_ack_q  <= 1'b0;
      lcd_ack_q  <= 1'b0;
      dec_rd_q   <= '0;
      lcd_rd_q   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      rd_en_q    <= rd_en_nxt;
      wr_en_q    <= wr_en_nxt;
      dec_ack_q  <= dec_ack_nxt;
      lcd_ack_q  <= lcd_ack_nxt;
      // Request fields are frozen at grant so later input changes are ignored.
      if (grant) begin
        sel_lcd <= grant_lcd;
        op_wr   <= grant_wr;
        addr_q  <= grant_lcd ? bus.data_loc : bus.dec_addr;
        wdata_q <= grant_lcd ? '0 : bus.dec_wr_data;
      end
      if (state == ST_CAP) begin
        if (sel_lcd) lcd_rd_q <= bus.sram_rd_data;
        else         dec_rd_q <= bus.sram_rd_data;
      end
    end
  end

  assign bus.sram_addr    = addr_q;
  assign bus.sram_wr_data = wdata_q;
  assign bus.sram_rd_en   = rd_en_q;
  assign bus.sram_wr_en   = wr_en_q;
  assign bus.dec_ack      = dec_ack_q;
  assign bus.lcd_ack      = lcd_ack_q;
  assign bus.dec_rd_data  = dec_rd_q;
  assign bus.lcd_data     = lcd_rd_q;
  assign bus.dec_wait     = dec_req & ~dec_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;
  import cpu_pkg::*;

  logic clk;
  logic sys_rst;
  int   checks;
  int   errors;
  logic [7:0] mem [256];

  sram_arbiter_if bus ();

  sram_arbiter dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: read data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.sram_wr_en) mem[bus.sram_addr] <= bus.sram_wr_data;
    if (bus.sram_rd_en) bus.sram_rd_data <= mem[bus.sram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.dec_rd_en   = 1'b0;
    bus.dec_wr_en   = 1'b0;
    bus.dec_addr    = 8'h00;
    bus.dec_wr_data = 8'h00;
    bus.loc_req     = 1'b0;
    bus.data_loc    = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    sys_rst = 1'b0;
    tick();
    checks++; if (bus.sram_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bus.sram_rd_en); end
    checks++; if (bus.sram_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus.sram_wr_en); end
    checks++; if (bus.dec_ack !== 1'b0 || bus.lcd_ack !== 1'b0) begin errors++; $display("FAIL reset_acks: got %b%b want 00", bus.dec_ack, bus.lcd_ack); end
    checks++; if (bus.sram_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", bus.sram_addr); end
    checks++; if (bus.dec_rd_data !== 8'h00 || bus.lcd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h/%h want 00/00", bus.dec_rd_data, bus.lcd_data); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", dut.state); end
    bus.dec_rd_en = 1'b1;
    #1;
    checks++; if (bus.dec_wait !== 1'b1) begin errors++; $display("FAIL reset_wait: got %b want 1", bus.dec_wait); end
    bus.dec_rd_en = 1'b0;
    #1;
    checks++; if (bus.dec_wait !== 1'b0) begin errors++; $display("FAIL reset_wait_low: got %b want 0", bus.dec_wait); end
    sys_rst = 1'b1;
    tick();
  endtask

  task automatic test_write();
    bus.dec_wr_en   = 1'b1;
    bus.dec_addr    = 8'h10;
    bus.dec_wr_data = 8'h5A;
    #1;
    checks++; if (bus.dec_wait !== 1'b1) begin errors++; $display("FAIL wr_wait_c0: got %b want 1", bus.dec_wait); end
    tick();
    checks++; if (bus.sram_wr_en !== 1'b1 || bus.sram_rd_en !== 1'b0) begin errors++; $display("FAIL wr_strobes_c1: got wr=%b rd=%b want wr=1 rd=0", bus.sram_wr_en, bus.sram_rd_en); end
    checks++; if (bus.sram_addr !== 8'h10 || bus.sram_wr_data !== 8'h5A) begin errors++; $display("FAIL wr_addr_data_c1: got %h/%h want 10/5a", bus.sram_addr, bus.sram_wr_data); end
    checks++; if (bus.dec_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_c1: got %b want 0", bus.dec_ack); end
    bus.dec_addr    = 8'h33;
    bus.dec_wr_data = 8'hFF;
    tick();
    checks++; if (bus.dec_ack !== 1'b1 || bus.sram_wr_en !== 1'b0) begin errors++; $display("FAIL wr_ack_c2: got ack=%b wr=%b want ack=1 wr=0", bus.dec_ack, bus.sram_wr_en); end
    checks++; if (bus.dec_wait !== 1'b0) begin errors++; $display("FAIL wr_wait_c2: got %b want 0", bus.dec_wait); end
    idle_inputs();
    tick();
    checks++; if (bus.dec_ack !== 1'b0 || dut.state !== ST_IDLE) begin errors++; $display("FAIL wr_done_c3: got ack=%b state=%0d want 0/0", bus.dec_ack, dut.state); end
    checks++; if (mem[8'h10] !== 8'h5A || mem[8'h33] === 8'hFF) begin errors++; $display("FAIL wr_mem: got mem10=%h mem33=%h want 5a/not ff", mem[8'h10], mem[8'h33]); end
  endtask

  task automatic test_read();
    bus.dec_rd_en = 1'b1;
    bus.dec_addr  = 8'h10;
    tick();
    checks++; if (bus.sram_rd_en !== 1'b1 || bus.sram_wr_en !== 1'b0 || bus.sram_addr !== 8'h10) begin errors++; $display("FAIL rd_c1: got rd=%b wr=%b addr=%h want 1/0/10", bus.sram_rd_en, bus.sram_wr_en, bus.sram_addr); end
    bus.dec_addr = 8'h44;
    tick();
    checks++; if (bus.sram_rd_en !== 1'b0 || bus.dec_ack !== 1'b0) begin errors++; $display("FAIL rd_c2: got rd=%b ack=%b want 0/0", bus.sram_rd_en, bus.dec_ack); end
    tick();
    checks++; if (bus.dec_ack !== 1'b1 || bus.dec_rd_data !== 8'h5A) begin errors++; $display("FAIL rd_c3: got ack=%b data=%h want 1/5a", bus.dec_ack, bus.dec_rd_data); end
    idle_inputs();
    tick();
    checks++; if (bus.dec_ack !== 1'b0 || bus.dec_rd_data !== 8'h5A) begin errors++; $display("FAIL rd_hold_c4: got ack=%b data=%h want 0/5a", bus.dec_ack, bus.dec_rd_data); end
  endtask

  task automatic test_both_enables();
    int rd_seen = 0;
    int ack_cyc = -1;
    bus.dec_rd_en   = 1'b1;
    bus.dec_wr_en   = 1'b1;
    bus.dec_addr    = 8'h30;
    bus.dec_wr_data = 8'hC3;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (bus.sram_rd_en) rd_seen++;
      if (bus.dec_ack) begin ack_cyc = c; idle_inputs(); end
    end
    checks++; if (rd_seen !== 0) begin errors++; $display("FAIL both_rd_en: got %0d rd strobes want 0", rd_seen); end
    checks++; if (ack_cyc !== 2) begin errors++; $display("FAIL both_ack_cycle: got %0d want 2", ack_cyc); end
    checks++; if (mem[8'h30] !== 8'hC3) begin errors++; $display("FAIL both_mem: got %h want c3", mem[8'h30]); end
  endtask

  task automatic test_contention();
    int dec_cyc = -1;
    int lcd_cyc = -1;
    logic [7:0] lcd_val = 8'h00;
    bus.dec_rd_en = 1'b1;
    bus.dec_addr  = 8'h10;
    bus.loc_req   = 1'b1;
    bus.data_loc  = 8'h20;
    for (int c = 1; c <= 20 && lcd_cyc < 0; c++) begin
      tick();
      if (bus.dec_ack) begin dec_cyc = c; bus.dec_rd_en = 1'b0; end
      if (bus.lcd_ack) begin lcd_cyc = c; lcd_val = bus.lcd_data; bus.loc_req = 1'b0; end
    end
    idle_inputs();
    checks++; if (dec_cyc !== 3) begin errors++; $display("FAIL cont_dec_ack_cycle: got %0d want 3", dec_cyc); end
    checks++; if (lcd_cyc !== 7) begin errors++; $display("FAIL cont_lcd_ack_cycle: got %0d want 7", lcd_cyc); end
    checks++; if (lcd_val !== 8'h77) begin errors++; $display("FAIL cont_lcd_data: got %h want 77", lcd_val); end
    tick();
  endtask

  task automatic test_starvation();
    int dec_acks = 0;
    int dec_before = -1;
    int lcd_cyc = -1;
    logic [7:0] lcd_val = 8'h00;
    bus.dec_rd_en = 1'b1;
    bus.dec_addr  = 8'h10;
    bus.loc_req   = 1'b1;
    bus.data_loc  = 8'h20;
    for (int c = 1; c <= 40 && lcd_cyc < 0; c++) begin
      tick();
      if (bus.dec_ack) dec_acks++;
      if (bus.lcd_ack) begin lcd_cyc = c; lcd_val = bus.lcd_data; dec_before = dec_acks; end
    end
    idle_inputs();
    checks++; if (dec_before !== 3) begin errors++; $display("FAIL starve_dec_grants: got %0d want 3", dec_before); end
    checks++; if (lcd_cyc !== 15) begin errors++; $display("FAIL starve_lcd_cycle: got %0d want 15", lcd_cyc); end
    checks++; if (lcd_val !== 8'h77) begin errors++; $display("FAIL starve_lcd_data: got %h want 77", lcd_val); end
    tick();
  endtask

  task automatic test_reset_in_flight();
    int acks = 0;
    bus.dec_rd_en = 1'b1;
    bus.dec_addr  = 8'h10;
    tick();
    checks++; if (bus.sram_rd_en !== 1'b1) begin errors++; $display("FAIL rst_pre_acc: got rd=%b want 1", bus.sram_rd_en); end
    #1;
    sys_rst = 1'b0;
    #1;
    checks++; if (bus.sram_rd_en !== 1'b0 || bus.sram_wr_en !== 1'b0) begin errors++; $display("FAIL rst_strobes: got rd=%b wr=%b want 0/0", bus.sram_rd_en, bus.sram_wr_en); end
    checks++; if (bus.dec_ack !== 1'b0 || bus.lcd_ack !== 1'b0 || dut.state !== ST_IDLE) begin errors++; $display("FAIL rst_acks_state: got %b%b state=%0d want 00/0", bus.dec_ack, bus.lcd_ack, dut.state); end
    tick();
    idle_inputs();
    sys_rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.dec_ack || bus.lcd_ack) acks++;
    end
    checks++; if (acks !== 0 || dut.state !== ST_IDLE) begin errors++; $display("FAIL rst_no_ack: got %0d acks state=%0d want 0/0", acks, dut.state); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h77;
    bus.sram_rd_data = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_both_enables();
    test_contention();
    test_starvation();
    test_reset_in_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
